// File: rtl/mem_arbiter.sv
// Two-port arbiter sharing a single-port registered-output RAM between port A (CPU) and port B (loader).
// Define ARB_RR_EN for round-robin arbitration in IDLE; otherwise port A has fixed priority.
module mem_arbiter #(
    parameter int unsigned AW       = 8,
    parameter int unsigned DW       = 16,
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          a_req,
    input  logic          a_we,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_wdata,
    input  logic          a_lock,
    output logic          a_gnt,
    output logic          a_rvalid,
    output logic [DW-1:0] a_rdata,
    input  logic          b_req,
    input  logic          b_we,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_wdata,
    input  logic          b_lock,
    output logic          b_gnt,
    output logic          b_rvalid,
    output logic [DW-1:0] b_rdata,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_din,
    input  logic [DW-1:0] ram_dout
);
    localparam int unsigned   HW       = 8;
    localparam logic [HW-1:0] HOLD_LIM = HW'(MAX_HOLD);
    localparam logic [HW-1:0] HOLD_SAT = '1;

    typedef enum logic [1:0] {IDLE, OWN_A, OWN_B} state_e;
    typedef enum logic {PORT_A = 1'b0, PORT_B = 1'b1} port_e;

    state_e        state_q, state_d;
    logic [HW-1:0] hold_q, hold_d;
    port_e         last_q, last_d;
    logic          pend_vld_q, pend_vld_d;
    port_e         pend_port_q, pend_port_d;

    logic gnt_a, gnt_b, gnt_own, gnt_oth;
    logic own_is_a, own_req, oth_req, own_lock;
    logic prefer_a, pick_a, pick_b;

    // Owner/other view of the two ports while a lock is held
    assign own_is_a = (state_q == OWN_A);
    assign own_req  = own_is_a ? a_req  : b_req;
    assign oth_req  = own_is_a ? b_req  : a_req;
    assign own_lock = own_is_a ? a_lock : b_lock;

`ifdef ARB_RR_EN
    assign prefer_a = (last_q == PORT_B);
`else
    assign prefer_a = 1'b1;
`endif
    assign pick_a = a_req && (!b_req || prefer_a);
    assign pick_b = b_req && !pick_a;

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        last_d  = last_q;
        gnt_a   = 1'b0;
        gnt_b   = 1'b0;
        gnt_own = 1'b0;
        gnt_oth = 1'b0;
        case (state_q)
            IDLE: begin
                gnt_a  = pick_a;
                gnt_b  = pick_b;
                hold_d = '0;
                if (pick_a && a_lock) begin
                    state_d = OWN_A;
                    hold_d  = HW'(1);
                end else if (pick_b && b_lock) begin
                    state_d = OWN_B;
                    hold_d  = HW'(1);
                end
            end
            OWN_A, OWN_B: begin
                if (!own_req) begin
                    // Owner went away: release, the other port may use this slot
                    gnt_oth = oth_req;
                    state_d = IDLE;
                    hold_d  = '0;
                end else if (oth_req && hold_q == HOLD_LIM) begin
                    gnt_oth = 1'b1;
                    hold_d  = '0;
                end else begin
                    gnt_own = 1'b1;
                    if (!oth_req)
                        hold_d = '0;
                    else if (hold_q != HOLD_SAT)
                        hold_d = hold_q + HW'(1);
                    if (!own_lock) begin
                        state_d = IDLE;
                        hold_d  = '0;
                    end
                end
                gnt_a = own_is_a ? gnt_own : gnt_oth;
                gnt_b = own_is_a ? gnt_oth : gnt_own;
            end
            default: begin
                state_d = IDLE;
                hold_d  = '0;
            end
        endcase
        if (gnt_a)
            last_d = PORT_A;
        else if (gnt_b)
            last_d = PORT_B;
        pend_vld_d  = (gnt_a && !a_we) || (gnt_b && !b_we);
        pend_port_d = gnt_b ? PORT_B : PORT_A;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            hold_q      <= '0;
            last_q      <= PORT_B;
            pend_vld_q  <= 1'b0;
            pend_port_q <= PORT_A;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            last_q      <= last_d;
            pend_vld_q  <= pend_vld_d;
            pend_port_q <= pend_port_d;
        end
    end

    // Everything is forced low while reset is asserted
    assign a_gnt    = rst && gnt_a;
    assign b_gnt    = rst && gnt_b;
    assign ram_we   = a_gnt ? a_we    : (b_gnt ? b_we    : 1'b0);
    assign ram_addr = a_gnt ? a_addr  : (b_gnt ? b_addr  : '0);
    assign ram_din  = a_gnt ? a_wdata : (b_gnt ? b_wdata : '0);

    assign a_rvalid = rst && pend_vld_q && (pend_port_q == PORT_A);
    assign b_rvalid = rst && pend_vld_q && (pend_port_q == PORT_B);
    assign a_rdata  = a_rvalid ? ram_dout : '0;
    assign b_rdata  = b_rvalid ? ram_dout : '0;
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed cycle table, then randomized traffic against a behavioural model.
module tb_mem_arbiter;
    localparam int MH = 2;
`ifdef ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    logic a_req, a_we, a_lock, b_req, b_we, b_lock;
    logic [7:0]  a_addr, b_addr;
    logic [15:0] a_wdata, b_wdata;
    logic a_gnt, a_rvalid, b_gnt, b_rvalid, ram_we;
    logic [15:0] a_rdata, b_rdata, ram_din, ram_dout;
    logic [7:0]  ram_addr;

    logic        ram_init;
    logic [15:0] ram [256];

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.AW(8), .DW(16), .MAX_HOLD(MH)) dut (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_lock(a_lock),
        .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_lock(b_lock),
        .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
    );

    // Single-port RAM with registered read data
    always @(posedge clk) begin
        if (ram_init) begin
            for (int i = 0; i < 256; i++) ram[i] <= (i == 16) ? 16'h1234 : 16'h0000;
            ram_dout <= 16'h0000;
        end else begin
            if (ram_we) ram[ram_addr] <= ram_din;
            ram_dout <= ram[ram_addr];
        end
    end

    typedef struct {
        string       name;
        logic        rst;
        logic        ar, awe, alk;
        logic [7:0]  aad;
        logic [15:0] awd;
        logic        br, bwe, blk;
        logic [7:0]  bad;
        logic [15:0] bwd;
        logic        eag, ebg, ewe;
        logic [7:0]  ead;
        logic [15:0] edin;
        logic        earv;
        logic [15:0] eard;
        logic        ebrv;
        logic [15:0] ebrd;
    } vec_t;

    vec_t vq[$];

    task automatic add(input string nm, input logic r,
                       input logic ar, input logic awe, input logic [7:0] aad, input logic [15:0] awd, input logic alk,
                       input logic br, input logic bwe, input logic [7:0] bad, input logic [15:0] bwd, input logic blk,
                       input logic eag, input logic ebg, input logic ewe, input logic [7:0] ead, input logic [15:0] edin,
                       input logic earv, input logic [15:0] eard, input logic ebrv, input logic [15:0] ebrd);
        vec_t v;
        v.name = nm; v.rst = r;
        v.ar = ar; v.awe = awe; v.aad = aad; v.awd = awd; v.alk = alk;
        v.br = br; v.bwe = bwe; v.bad = bad; v.bwd = bwd; v.blk = blk;
        v.eag = eag; v.ebg = ebg; v.ewe = ewe; v.ead = ead; v.edin = edin;
        v.earv = earv; v.eard = eard; v.ebrv = ebrv; v.ebrd = ebrd;
        vq.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic check_all(input string nm, input logic eag, input logic ebg, input logic ewe,
                             input logic [7:0] ead, input logic [15:0] edin, input logic earv,
                             input logic [15:0] eard, input logic ebrv, input logic [15:0] ebrd);
        chk({nm, ".gnt"}, 32'({a_gnt, b_gnt}), 32'({eag, ebg}));
        chk({nm, ".ram"}, 32'({ram_we, ram_addr, ram_din}), 32'({ewe, ead, edin}));
        chk({nm, ".a_rd"}, 32'({a_rvalid, a_rdata}), 32'({earv, eard}));
        chk({nm, ".b_rd"}, 32'({b_rvalid, b_rdata}), 32'({ebrv, ebrd}));
    endtask

    // Behavioural model state for the random phase
    int          m_owner, m_streak, m_last, m_pp, w, o, x;
    bit          m_pv;
    logic [15:0] m_pd;
    logic [15:0] m_mem [256];
    logic        r_req [2], r_we [2], r_lock [2];
    logic [7:0]  r_addr [2];
    logic [15:0] r_wd [2];
    bit          r_done [2];
    logic        rst_v;

    initial begin
        rst = 1'b0; ram_init = 1'b1;
        a_req = 0; a_we = 0; a_addr = 0; a_wdata = 0; a_lock = 0;
        b_req = 0; b_we = 0; b_addr = 0; b_wdata = 0; b_lock = 0;
        @(posedge clk); #1;
        ram_init = 1'b0;

        //   name          rst  A: req we addr  wdata    lk  B: req we addr  wdata    lk  exp: ag bg we addr  din      arv ard      brv brd
        add("rst_idle",    0,   0, 0, 8'h00, 16'h0000, 0,  0, 0, 8'h00, 16'h0000, 0,  0, 0, 0, 8'h00, 16'h0000, 0, 16'h0000, 0, 16'h0000);
        add("rst_gate",    0,   1, 0, 8'h10, 16'h0000, 0,  1, 0, 8'h11, 16'h0000, 0,  0, 0, 0, 8'h00, 16'h0000, 0, 16'h0000, 0, 16'h0000);
        add("a_rd10",      1,   1, 0, 8'h10, 16'h0000, 0,  0, 0, 8'h00, 16'h0000, 0,  1, 0, 0, 8'h10, 16'h0000, 0, 16'h0000, 0, 16'h0000);
        add("b_rd10",      1,   0, 0, 8'h00, 16'h0000, 0,  1, 0, 8'h10, 16'h0000, 0,  0, 1, 0, 8'h10, 16'h0000, 1, 16'h1234, 0, 16'h0000);
        add("contest0",    1,   1, 0, 8'h10, 16'h0000, 0,  1, 0, 8'h11, 16'h0000, 0,  1, 0, 0, 8'h10, 16'h0000, 0, 16'h0000, 1, 16'h1234);
        if (RR) begin
        add("contest1",    1,   1, 0, 8'h10, 16'h0000, 0,  1, 0, 8'h11, 16'h0000, 0,  0, 1, 0, 8'h11, 16'h0000, 1, 16'h1234, 0, 16'h0000);
        add("contest2",    1,   1, 0, 8'h10, 16'h0000, 0,  1, 0, 8'h11, 16'h0000, 0,  1, 0, 0, 8'h10, 16'h0000, 0, 16'h0000, 1, 16'h0000);
        add("contest3",    1,   1, 0, 8'h10, 16'h0000, 0,  1, 0, 8'h11, 16'h0000, 0,  0, 1, 0, 8'h11, 16'h0000, 1, 16'h1234, 0, 16'h0000);
        add("contest_end", 1,   0, 0, 8'h00, 16'h0000, 0,  0, 0, 8'h00, 16'h0000, 0,  0, 0, 0, 8'h00, 16'h0000, 0, 16'h0000, 1, 16'h0000);
        end else begin
        add("contest1",    1,   1, 0, 8'h10, 16'h0000, 0,  1, 0, 8'h11, 16'h0000, 0,  1, 0, 0, 8'h10, 16'h0000, 1, 16'h1234, 0, 16'h0000);
        add("contest2",    1,   1, 0, 8'h10, 16'h0000, 0,  1, 0, 8'h11, 16'h0000, 0,  1, 0, 0, 8'h10, 16'h0000, 1, 16'h1234, 0, 16'h0000);
        add("contest3",    1,   1, 0, 8'h10, 16'h0000, 0,  1, 0, 8'h11, 16'h0000, 0,  1, 0, 0, 8'h10, 16'h0000, 1, 16'h1234, 0, 16'h0000);
        add("contest_end", 1,   0, 0, 8'h00, 16'h0000, 0,  0, 0, 8'h00, 16'h0000, 0,  0, 0, 0, 8'h00, 16'h0000, 1, 16'h1234, 0, 16'h0000);
        end
        for (int k = 0; k < 3; k++)
        add("b_wr_lock",   1,   0, 0, 8'h00, 16'h0000, 0,  1, 1, 8'h20, 16'hBEEF, 1,  0, 1, 1, 8'h20, 16'hBEEF, 0, 16'h0000, 0, 16'h0000);
        add("b_wr_unlock", 1,   0, 0, 8'h00, 16'h0000, 0,  1, 1, 8'h20, 16'hBEEF, 0,  0, 1, 1, 8'h20, 16'hBEEF, 0, 16'h0000, 0, 16'h0000);
        add("release",     1,   1, 0, 8'h20, 16'h0000, 0,  1, 0, 8'h21, 16'h0000, 0,  1, 0, 0, 8'h20, 16'h0000, 0, 16'h0000, 0, 16'h0000);
        add("b_after",     1,   0, 0, 8'h00, 16'h0000, 0,  1, 0, 8'h21, 16'h0000, 0,  0, 1, 0, 8'h21, 16'h0000, 1, 16'hBEEF, 0, 16'h0000);
        add("idle1",       1,   0, 0, 8'h00, 16'h0000, 0,  0, 0, 8'h00, 16'h0000, 0,  0, 0, 0, 8'h00, 16'h0000, 0, 16'h0000, 1, 16'h0000);
        add("hold_b0",     1,   0, 0, 8'h00, 16'h0000, 0,  1, 0, 8'h10, 16'h0000, 1,  0, 1, 0, 8'h10, 16'h0000, 0, 16'h0000, 0, 16'h0000);
        add("hold_b1",     1,   1, 0, 8'h20, 16'h0000, 0,  1, 0, 8'h10, 16'h0000, 1,  0, 1, 0, 8'h10, 16'h0000, 0, 16'h0000, 1, 16'h1234);
        add("yield_a",     1,   1, 0, 8'h20, 16'h0000, 0,  1, 0, 8'h10, 16'h0000, 1,  1, 0, 0, 8'h20, 16'h0000, 0, 16'h0000, 1, 16'h1234);
        add("hold_b2",     1,   1, 0, 8'h20, 16'h0000, 0,  1, 0, 8'h10, 16'h0000, 1,  0, 1, 0, 8'h10, 16'h0000, 1, 16'hBEEF, 0, 16'h0000);
        add("hold_b3",     1,   1, 0, 8'h20, 16'h0000, 0,  1, 0, 8'h10, 16'h0000, 1,  0, 1, 0, 8'h10, 16'h0000, 0, 16'h0000, 1, 16'h1234);
        add("yield_a2",    1,   1, 0, 8'h20, 16'h0000, 0,  1, 0, 8'h10, 16'h0000, 1,  1, 0, 0, 8'h20, 16'h0000, 0, 16'h0000, 1, 16'h1234);
        add("own_drop",    1,   1, 0, 8'h20, 16'h0000, 0,  0, 0, 8'h00, 16'h0000, 0,  1, 0, 0, 8'h20, 16'h0000, 1, 16'hBEEF, 0, 16'h0000);
        add("idle2",       1,   0, 0, 8'h00, 16'h0000, 0,  0, 0, 8'h00, 16'h0000, 0,  0, 0, 0, 8'h00, 16'h0000, 1, 16'hBEEF, 0, 16'h0000);
        add("a_lock_rd",   1,   1, 0, 8'h10, 16'h0000, 1,  0, 0, 8'h00, 16'h0000, 0,  1, 0, 0, 8'h10, 16'h0000, 0, 16'h0000, 0, 16'h0000);
        add("rst_mid",     0,   1, 0, 8'h10, 16'h0000, 1,  0, 0, 8'h00, 16'h0000, 0,  0, 0, 0, 8'h00, 16'h0000, 0, 16'h0000, 0, 16'h0000);
        add("post_rst",    1,   0, 0, 8'h00, 16'h0000, 0,  0, 0, 8'h00, 16'h0000, 0,  0, 0, 0, 8'h00, 16'h0000, 0, 16'h0000, 0, 16'h0000);
        add("b_lock_new",  1,   0, 0, 8'h00, 16'h0000, 0,  1, 0, 8'h11, 16'h0000, 1,  0, 1, 0, 8'h11, 16'h0000, 0, 16'h0000, 0, 16'h0000);
        add("b_own",       1,   1, 0, 8'h20, 16'h0000, 0,  1, 0, 8'h11, 16'h0000, 1,  0, 1, 0, 8'h11, 16'h0000, 0, 16'h0000, 1, 16'h0000);
        add("b_yield",     1,   1, 0, 8'h20, 16'h0000, 0,  1, 0, 8'h11, 16'h0000, 1,  1, 0, 0, 8'h20, 16'h0000, 0, 16'h0000, 1, 16'h0000);
        add("b_unlock",    1,   1, 0, 8'h20, 16'h0000, 0,  1, 0, 8'h11, 16'h0000, 0,  0, 1, 0, 8'h11, 16'h0000, 1, 16'hBEEF, 0, 16'h0000);
        add("a_rd20",      1,   1, 0, 8'h20, 16'h0000, 0,  0, 0, 8'h00, 16'h0000, 0,  1, 0, 0, 8'h20, 16'h0000, 0, 16'h0000, 1, 16'h0000);
        add("a_wr07",      1,   1, 1, 8'h07, 16'h0055, 0,  0, 0, 8'h00, 16'h0000, 0,  1, 0, 1, 8'h07, 16'h0055, 1, 16'hBEEF, 0, 16'h0000);
        add("a_rd07",      1,   1, 0, 8'h07, 16'h0000, 0,  0, 0, 8'h00, 16'h0000, 0,  1, 0, 0, 8'h07, 16'h0000, 0, 16'h0000, 0, 16'h0000);
        add("idle_last",   1,   0, 0, 8'h00, 16'h0000, 0,  0, 0, 8'h00, 16'h0000, 0,  0, 0, 0, 8'h00, 16'h0000, 1, 16'h0055, 0, 16'h0000);

        foreach (vq[i]) begin
            rst = vq[i].rst;
            a_req = vq[i].ar; a_we = vq[i].awe; a_addr = vq[i].aad; a_wdata = vq[i].awd; a_lock = vq[i].alk;
            b_req = vq[i].br; b_we = vq[i].bwe; b_addr = vq[i].bad; b_wdata = vq[i].bwd; b_lock = vq[i].blk;
            @(negedge clk);
            check_all(vq[i].name, vq[i].eag, vq[i].ebg, vq[i].ewe, vq[i].ead, vq[i].edin,
                      vq[i].earv, vq[i].eard, vq[i].ebrv, vq[i].ebrd);
            @(posedge clk); #1;
        end

        // Random traffic against the model, starting from a reset cycle
        for (int i = 0; i < 256; i++) m_mem[i] = ram[i];
        m_owner = -1; m_streak = 0; m_last = 1; m_pv = 1'b0; m_pp = 0; m_pd = '0;
        for (int p = 0; p < 2; p++) begin
            r_req[p] = 0; r_we[p] = 0; r_lock[p] = 0; r_addr[p] = 0; r_wd[p] = 0; r_done[p] = 1'b1;
        end
        for (int cyc = 0; cyc < 3000; cyc++) begin
            rst_v = !((cyc == 0) || ($urandom_range(0, 63) == 0));
            for (int p = 0; p < 2; p++) begin
                if (r_done[p] || !r_req[p]) begin
                    r_req[p]  = ($urandom_range(0, 3) != 0);
                    r_we[p]   = $urandom_range(0, 1) == 1;
                    r_addr[p] = 8'($urandom_range(0, 15));
                    r_wd[p]   = 16'($urandom);
                    r_lock[p] = ($urandom_range(0, 2) == 0);
                end
                r_done[p] = 1'b0;
            end
            rst = rst_v;
            a_req = r_req[0]; a_we = r_we[0]; a_addr = r_addr[0]; a_wdata = r_wd[0]; a_lock = r_lock[0];
            b_req = r_req[1]; b_we = r_we[1]; b_addr = r_addr[1]; b_wdata = r_wd[1]; b_lock = r_lock[1];

            w = -1;
            if (rst_v) begin
                if (m_owner < 0) begin
                    if (r_req[0] && r_req[1]) w = RR ? (1 - m_last) : 0;
                    else if (r_req[0])        w = 0;
                    else if (r_req[1])        w = 1;
                end else begin
                    o = m_owner; x = 1 - m_owner;
                    if (!r_req[o])                         w = r_req[x] ? x : -1;
                    else if (r_req[x] && m_streak == MH)   w = x;
                    else                                   w = o;
                end
            end

            @(negedge clk);
            check_all("rand", w == 0, w == 1,
                      (w >= 0) ? r_we[w] : 1'b0,
                      (w >= 0) ? r_addr[w] : 8'h00,
                      (w >= 0) ? r_wd[w] : 16'h0000,
                      rst_v && m_pv && m_pp == 0, (rst_v && m_pv && m_pp == 0) ? m_pd : 16'h0000,
                      rst_v && m_pv && m_pp == 1, (rst_v && m_pv && m_pp == 1) ? m_pd : 16'h0000);

            if (!rst_v) begin
                m_owner = -1; m_streak = 0; m_last = 1; m_pv = 1'b0;
            end else begin
                if (m_owner < 0) begin
                    if (w >= 0 && r_lock[w]) begin
                        m_owner = w; m_streak = 1;
                    end
                end else begin
                    o = m_owner; x = 1 - m_owner;
                    if (w == o) begin
                        m_streak = r_req[x] ? ((m_streak < 255) ? m_streak + 1 : 255) : 0;
                        if (!r_lock[o]) begin m_owner = -1; m_streak = 0; end
                    end else if (r_req[o]) begin
                        m_streak = 0;
                    end else begin
                        m_owner = -1; m_streak = 0;
                    end
                end
                m_pv = 1'b0;
                if (w >= 0) begin
                    m_last = w;
                    r_done[w] = 1'b1;
                    if (r_we[w]) m_mem[r_addr[w]] = r_wd[w];
                    else begin
                        m_pv = 1'b1; m_pp = w; m_pd = m_mem[r_addr[w]];
                    end
                end
            end
            @(posedge clk); #1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-requester arbiter that shares the single-port 256x16 block RAM between the CPU core (port A) and a host/debug loader (port B).
- Issues at most one RAM access per cycle and returns read data to the granted requester one cycle later, matching the RAM's registered-output latency.
- A lock input lets one requester keep ownership for back-to-back bursts, e.g. program load or a read-modify-write sequence.

Parameters:
- AW, 8, address width (RAM depth 2**AW)
- DW, 16, data width
- MAX_HOLD, 8, max consecutive locked grants to one owner while the other port is waiting (range 1..255)

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-low
- a_req  in  1  port A access request
- a_we  in  1  port A write (1) / read (0)
- a_addr  in  AW  port A address
- a_wdata  in  DW  port A write data
- a_lock  in  1  port A requests to keep ownership after this grant
- a_gnt  out  1  port A access issued this cycle
- a_rvalid  out  1  port A read data valid
- a_rdata  out  DW  port A read data
- b_req, b_we, b_addr, b_wdata, b_lock, b_gnt, b_rvalid, b_rdata: same as port A, for port B
- ram_we  out  1  RAM write enable
- ram_addr  out  AW  RAM address
- ram_din  out  DW  RAM write data
- ram_dout  in  DW  RAM registered read data

Behaviour:
- Reset (rst==0 at a clk edge):
  - state=IDLE, hold_cnt=0, last_gnt=B, rd_pend=0.
  - All outputs 0 while rst==0.
  - A read issued in the cycle before reset never produces rvalid.
- Handshake:
  - A requester holds req/we/addr/wdata/lock stable until it sees gnt. gnt is combinational, in the same cycle the access is driven to the RAM.
  - Exactly one of a_gnt/b_gnt, or neither, is high per cycle. A port is granted only if its req==1.
- RAM drive:
  - On grant, ram_addr/ram_din/ram_we are copied from the winner.
  - With no grant: ram_we=0, ram_addr=0, ram_din=0.
- Read return:
  - A granted read sets rd_pend={valid, port} at the edge.
  - On the next cycle the arbiter asserts x_rvalid for 1 cycle on that port, with x_rdata=ram_dout.
  - x_rdata=0 when x_rvalid=0.
  - Writes never produce rvalid.
  - Back-to-back reads give one rvalid per cycle. A new grant in the rvalid cycle is allowed.
- State machine: IDLE, OWN_A, OWN_B.
  - IDLE: the winner is chosen by the priority policy. If the winner's lock==1 at grant, go to OWN_x with hold_cnt=1. Otherwise stay in IDLE.
  - OWN_x, owner req==1 and (other req==0 or hold_cnt<MAX_HOLD): grant the owner and increment hold_cnt, saturating at 255. hold_cnt resets to 0 on any edge where the other port's req==0.
  - OWN_x, owner req==1, other waiting, hold_cnt==MAX_HOLD: grant the other port this cycle (forced yield), clear hold_cnt, stay in OWN_x.
  - OWN_x, owner req==0 or owner lock==0 while granted: release to IDLE after this cycle. The last access carrying lock==0 is still granted.
  - OWN_x, owner req==0: the other port may be granted in the same cycle by the IDLE policy.
  - The non-owner's lock is ignored while OWN_x.
- Priority policy (IDLE): fixed, A over B, unless ARB_RR_EN is defined.
- last_gnt updates on every grant.
- Width: addresses and data pass through unmodified; no arithmetic on the data path.

Optional Feature:
- Macro ARB_RR_EN.
- Defined: in IDLE with both req==1, grant the port != last_gnt (round-robin). Because last_gnt resets to B, the first contest goes to A.
- Undefined: A always wins in IDLE; last_gnt is kept but unused for arbitration.

Test Plan:
- Reset, then A read addr 0x10 (mem=0x1234): a_gnt same cycle, ram_addr=0x10, ram_we=0; next cycle a_rvalid=1, a_rdata=0x1234; b_rvalid=0 throughout.
- A and B request together, no lock, 4 cycles:
  - Fixed priority: A granted every cycle, b_gnt=0.
  - ARB_RR_EN: grants A,B,A,B.
- B write 0xBEEF at 0x20 with b_lock=1 for 3 beats while A idle: b_gnt 3 consecutive cycles, ram_we=1, state OWN_B; on the 4th beat with b_lock=0, B is granted and state returns to IDLE; A read of 0x20 then returns 0xBEEF.
- MAX_HOLD=2, B locked and streaming, A requesting continuously: grants B,B,A,B,B,A...; each A read yields a_rvalid exactly 1 cycle after its a_gnt.
- Reset mid-read: grant A read, pull rst low on the next edge: a_rvalid stays 0, all outputs 0; after release, state IDLE and a lock held before reset is gone.
- Write-then-read same address: A write 0x0055 to 0x07, then A read 0x07 the following cycle: a_rvalid with 0x0055; no rvalid for the write cycle.
